// File: rtl/regfile_wb.sv
// Register file and writeback stage for the 6809/6309 core: operand read ports,
// one-cycle pending writeback of the ALU result and flags, and byte-granular forwarding.
module regfile_wb #(
  parameter logic [7:0]  CC_RESET    = 8'h50,
  parameter logic [15:0] UNUSED_READ = 16'hFFFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        issue_valid_in,
  input  logic [3:0]  issue_dst_in,
  input  logic        issue_wr_in,
  input  logic        issue_wcc_in,
  input  logic        issue_sz_in,
  input  logic [15:0] alu_q_in,
  input  logic [7:0]  alu_ccr_in,
  input  logic [3:0]  rd_sel_a_in,
  input  logic [3:0]  rd_sel_b_in,
  input  logic [15:0] pc_in,
  output logic [15:0] rd_a_out,
  output logic [15:0] rd_b_out,
  output logic [7:0]  ccr_out,
  output logic        pc_wr_out,
  output logic [15:0] pc_wr_data_out
);

  localparam logic [3:0] REG_D  = 4'h0;
  localparam logic [3:0] REG_X  = 4'h1;
  localparam logic [3:0] REG_Y  = 4'h2;
  localparam logic [3:0] REG_U  = 4'h3;
  localparam logic [3:0] REG_S  = 4'h4;
  localparam logic [3:0] REG_PC = 4'h5;
  localparam logic [3:0] REG_A  = 4'h8;
  localparam logic [3:0] REG_B  = 4'h9;
  localparam logic [3:0] REG_CC = 4'hA;
  localparam logic [3:0] REG_DP = 4'hB;

  logic [7:0]  a_q, a_d, b_q, b_d, dp_q, dp_d, cc_q, cc_d;
  logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  pend_dst_q, pend_dst_d;
  logic        pend_wr_q, pend_wr_d, pend_wcc_q, pend_wcc_d, pend_sz_q, pend_sz_d;
  logic        wr_en, pc_wr;
  logic [15:0] wide_val;
  logic [15:0] rd_view [16];

  // Pending stage captures the issue controls; the ALU result arrives next cycle.
  always_comb begin
    pend_valid_d = issue_valid_in;
    pend_dst_d   = issue_valid_in ? issue_dst_in : 4'h0;
    pend_wr_d    = issue_valid_in & issue_wr_in;
    pend_wcc_d   = issue_valid_in & issue_wcc_in;
    pend_sz_d    = issue_valid_in & issue_sz_in;
  end

  // Next register values double as the forwarding source for the read ports.
  always_comb begin
    a_d = a_q; b_d = b_q; dp_d = dp_q; cc_d = cc_q;
    x_d = x_q; y_d = y_q; u_d = u_q; s_d = s_q;
    pc_wr    = 1'b0;
    wr_en    = pend_valid_q & pend_wr_q;
    wide_val = pend_sz_q ? alu_q_in : {8'hFF, alu_q_in[7:0]};
    if (pend_valid_q && pend_wcc_q) cc_d = alu_ccr_in;
    if (wr_en) begin
      case (pend_dst_q)
        REG_D: begin
          a_d = pend_sz_q ? alu_q_in[15:8] : 8'hFF;
          b_d = alu_q_in[7:0];
        end
        REG_X:  x_d   = wide_val;
        REG_Y:  y_d   = wide_val;
        REG_U:  u_d   = wide_val;
        REG_S:  s_d   = wide_val;
        REG_PC: pc_wr = 1'b1;
        REG_A:  a_d   = alu_q_in[7:0];
        REG_B:  b_d   = alu_q_in[7:0];
        REG_CC: cc_d  = alu_q_in[7:0];
        REG_DP: dp_d  = alu_q_in[7:0];
        default: ;
      endcase
    end
  end

  // CC is read from the register only, so flags never loop back through the ALU.
  always_comb begin
    for (int i = 0; i < 16; i++) rd_view[i] = UNUSED_READ;
    rd_view[REG_D]  = {a_d, b_d};
    rd_view[REG_X]  = x_d;
    rd_view[REG_Y]  = y_d;
    rd_view[REG_U]  = u_d;
    rd_view[REG_S]  = s_d;
    rd_view[REG_PC] = pc_in;
    rd_view[REG_A]  = {8'hFF, a_d};
    rd_view[REG_B]  = {8'hFF, b_d};
    rd_view[REG_CC] = {8'hFF, cc_q};
    rd_view[REG_DP] = {8'hFF, dp_d};
  end

  assign rd_a_out       = rd_view[rd_sel_a_in];
  assign rd_b_out       = rd_view[rd_sel_b_in];
  assign ccr_out        = cc_q;
  assign pc_wr_out      = pc_wr & ~rst_in;
  assign pc_wr_data_out = pc_wr_out ? alu_q_in : 16'h0000;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q <= 8'h00; b_q <= 8'h00; dp_q <= 8'h00; cc_q <= CC_RESET;
      x_q <= 16'h0000; y_q <= 16'h0000; u_q <= 16'h0000; s_q <= 16'h0000;
      pend_valid_q <= 1'b0; pend_dst_q <= 4'h0;
      pend_wr_q <= 1'b0; pend_wcc_q <= 1'b0; pend_sz_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; dp_q <= dp_d; cc_q <= cc_d;
      x_q <= x_d; y_q <= y_d; u_q <= u_d; s_q <= s_d;
      pend_valid_q <= pend_valid_d; pend_dst_q <= pend_dst_d;
      pend_wr_q <= pend_wr_d; pend_wcc_q <= pend_wcc_d; pend_sz_q <= pend_sz_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset values, forwarding, width rules,
// CC conflicts, PC writes, back-to-back issue and mid-operation reset.
module tb_regfile_wb;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        issue_valid_in;
   logic [3:0]  issue_dst_in;
   logic        issue_wr_in;
   logic        issue_wcc_in;
   logic        issue_sz_in;
   logic [15:0] alu_q_in;
   logic [7:0]  alu_ccr_in;
   logic [3:0]  rd_sel_a_in;
   logic [3:0]  rd_sel_b_in;
   logic [15:0] pc_in;
   logic [15:0] rd_a_out;
   logic [15:0] rd_b_out;
   logic [7:0]  ccr_out;
   logic        pc_wr_out;
   logic [15:0] pc_wr_data_out;

   int vectors = 0;
   int miscompares = 0;

   regfile_wb dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .issue_valid_in(issue_valid_in), .issue_dst_in(issue_dst_in),
      .issue_wr_in(issue_wr_in), .issue_wcc_in(issue_wcc_in), .issue_sz_in(issue_sz_in),
      .alu_q_in(alu_q_in), .alu_ccr_in(alu_ccr_in),
      .rd_sel_a_in(rd_sel_a_in), .rd_sel_b_in(rd_sel_b_in), .pc_in(pc_in),
      .rd_a_out(rd_a_out), .rd_b_out(rd_b_out), .ccr_out(ccr_out),
      .pc_wr_out(pc_wr_out), .pc_wr_data_out(pc_wr_data_out)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk_in = ~clk_in;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic [3:0] dst, input logic wr, input logic wcc, input logic sz);
      issue_valid_in = 1'b1;
      issue_dst_in   = dst;
      issue_wr_in    = wr;
      issue_wcc_in   = wcc;
      issue_sz_in    = sz;
   endtask

   task automatic idle();
      issue_valid_in = 1'b0;
      issue_dst_in   = 4'h0;
      issue_wr_in    = 1'b0;
      issue_wcc_in   = 1'b0;
      issue_sz_in    = 1'b0;
   endtask

   // Reset values of registers, CC and PC strobe, plus unused-code reads.
   task automatic test_reset();
      idle();
      alu_q_in = 16'h0000; alu_ccr_in = 8'h00; pc_in = 16'h1000;
      rst_in = 1'b1;
      step(); step();
      rst_in = 1'b0;
      rd_sel_a_in = 4'h1; rd_sel_b_in = 4'h8;
      #1;
      vectors++; if (rd_a_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_x got %h want 0000", rd_a_out); end
      vectors++; if (rd_b_out !== 16'hFF00) begin miscompares++; $display("[TB] FAIL reset_a got %h want FF00", rd_b_out); end
      vectors++; if (ccr_out !== 8'h50) begin miscompares++; $display("[TB] FAIL reset_cc got %h want 50", ccr_out); end
      vectors++; if (pc_wr_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pcwr got %b want 0", pc_wr_out); end
      rd_sel_a_in = 4'h6; rd_sel_b_in = 4'h5;
      #1;
      vectors++; if (rd_a_out !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL reset_unused got %h want FFFF", rd_a_out); end
      vectors++; if (rd_b_out !== 16'h1000) begin miscompares++; $display("[TB] FAIL read_pc got %h want 1000", rd_b_out); end
   endtask

   // 16-bit write to X, forwarded in N+1 and stored in N+2.
   task automatic test_forward16();
      rd_sel_a_in = 4'h1;
      step(); issue(4'h1, 1'b1, 1'b0, 1'b1);
      step(); idle(); alu_q_in = 16'h1234; #1;
      vectors++; if (rd_a_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL fwd16_n1 got %h want 1234", rd_a_out); end
      step(); alu_q_in = 16'h0000; #1;
      vectors++; if (rd_a_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL fwd16_n2 got %h want 1234", rd_a_out); end
   endtask

   // Byte merge into D, then a 16-bit D write read back as A and B.
   task automatic test_byte_merge();
      rd_sel_a_in = 4'h8; rd_sel_b_in = 4'h0;
      step(); issue(4'h8, 1'b1, 1'b0, 1'b0);
      step(); idle(); alu_q_in = 16'h00AB; #1;
      vectors++; if (rd_b_out !== 16'hAB00) begin miscompares++; $display("[TB] FAIL merge_n1 got %h want AB00", rd_b_out); end
      step(); alu_q_in = 16'h0000; #1;
      vectors++; if (rd_b_out !== 16'hAB00) begin miscompares++; $display("[TB] FAIL merge_n2 got %h want AB00", rd_b_out); end
      rd_sel_b_in = 4'h9;
      issue(4'h0, 1'b1, 1'b0, 1'b1);
      step(); idle(); alu_q_in = 16'h5A6B; #1;
      vectors++; if (rd_a_out !== 16'hFF5A) begin miscompares++; $display("[TB] FAIL dfwd_a got %h want FF5A", rd_a_out); end
      vectors++; if (rd_b_out !== 16'hFF6B) begin miscompares++; $display("[TB] FAIL dfwd_b got %h want FF6B", rd_b_out); end
      step(); alu_q_in = 16'h0000; #1;
      vectors++; if (rd_a_out !== 16'hFF5A) begin miscompares++; $display("[TB] FAIL dstore_a got %h want FF5A", rd_a_out); end
      vectors++; if (rd_b_out !== 16'hFF6B) begin miscompares++; $display("[TB] FAIL dstore_b got %h want FF6B", rd_b_out); end
   endtask

   // Width conversions: 8-bit result to D and to U, 16-bit result to DP.
   task automatic test_width();
      issue(4'h0, 1'b1, 1'b0, 1'b0);
      step(); issue(4'h3, 1'b1, 1'b0, 1'b0); alu_q_in = 16'h1234;
      step(); issue(4'hB, 1'b1, 1'b0, 1'b1); alu_q_in = 16'h1299;
      step(); idle(); alu_q_in = 16'h1277;
      step(); alu_q_in = 16'h0000;
      rd_sel_a_in = 4'h0; rd_sel_b_in = 4'h3; #1;
      vectors++; if (rd_a_out !== 16'hFF34) begin miscompares++; $display("[TB] FAIL d_8bit got %h want FF34", rd_a_out); end
      vectors++; if (rd_b_out !== 16'hFF99) begin miscompares++; $display("[TB] FAIL u_8bit got %h want FF99", rd_b_out); end
      rd_sel_a_in = 4'hB; #1;
      vectors++; if (rd_a_out !== 16'hFF77) begin miscompares++; $display("[TB] FAIL dp_16bit got %h want FF77", rd_a_out); end
   endtask

   // Flags-only write, and a register write to CC overriding the flags.
   task automatic test_cc();
      rd_sel_a_in = 4'h0; rd_sel_b_in = 4'h1;
      issue(4'h1, 1'b0, 1'b1, 1'b1);
      step(); idle(); alu_q_in = 16'hDEAD; alu_ccr_in = 8'h54; #1;
      vectors++; if (ccr_out !== 8'h50) begin miscompares++; $display("[TB] FAIL cmp_cc_n1 got %h want 50", ccr_out); end
      vectors++; if (rd_b_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL cmp_x_n1 got %h want 1234", rd_b_out); end
      step(); alu_q_in = 16'h0000; alu_ccr_in = 8'h00; #1;
      vectors++; if (ccr_out !== 8'h54) begin miscompares++; $display("[TB] FAIL cmp_cc_n2 got %h want 54", ccr_out); end
      vectors++; if (rd_b_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL cmp_x_n2 got %h want 1234", rd_b_out); end
      vectors++; if (rd_a_out !== 16'hFF34) begin miscompares++; $display("[TB] FAIL cmp_d_n2 got %h want FF34", rd_a_out); end
      issue(4'hA, 1'b1, 1'b1, 1'b0);
      step(); idle(); alu_q_in = 16'h0003; alu_ccr_in = 8'hFF;
      step(); alu_q_in = 16'h0000; alu_ccr_in = 8'h00; rd_sel_a_in = 4'hA; #1;
      vectors++; if (ccr_out !== 8'h03) begin miscompares++; $display("[TB] FAIL cc_conflict got %h want 03", ccr_out); end
      vectors++; if (rd_a_out !== 16'hFF03) begin miscompares++; $display("[TB] FAIL cc_read got %h want FF03", rd_a_out); end
   endtask

   // PC destination pulses the strobe for one cycle; unused and invalid writes are dropped.
   task automatic test_pc_write();
      issue(4'h5, 1'b1, 1'b0, 1'b1); #1;
      vectors++; if (pc_wr_out !== 1'b0) begin miscompares++; $display("[TB] FAIL pcwr_n got %b want 0", pc_wr_out); end
      step(); idle(); alu_q_in = 16'hC000; #1;
      vectors++; if (pc_wr_out !== 1'b1) begin miscompares++; $display("[TB] FAIL pcwr_n1 got %b want 1", pc_wr_out); end
      vectors++; if (pc_wr_data_out !== 16'hC000) begin miscompares++; $display("[TB] FAIL pcdata_n1 got %h want C000", pc_wr_data_out); end
      step(); #1;
      vectors++; if (pc_wr_out !== 1'b0) begin miscompares++; $display("[TB] FAIL pcwr_n2 got %b want 0", pc_wr_out); end
      vectors++; if (pc_wr_data_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL pcdata_n2 got %h want 0000", pc_wr_data_out); end
      issue(4'h6, 1'b1, 1'b0, 1'b1);
      step(); issue(4'h1, 1'b1, 1'b0, 1'b1); issue_valid_in = 1'b0; alu_q_in = 16'h4321;
      step(); idle(); alu_q_in = 16'h5555;
      step(); alu_q_in = 16'h0000; rd_sel_a_in = 4'h6; rd_sel_b_in = 4'h1; #1;
      vectors++; if (rd_a_out !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL unused_wr got %h want FFFF", rd_a_out); end
      vectors++; if (rd_b_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL invalid_wr got %h want 1234", rd_b_out); end
   endtask

   // Two dependent writes to X in consecutive cycles, each forwarded in turn.
   task automatic test_back_to_back();
      rd_sel_a_in = 4'h1;
      issue(4'h1, 1'b1, 1'b0, 1'b1);
      step(); issue(4'h1, 1'b1, 1'b0, 1'b1); alu_q_in = 16'h1111; #1;
      vectors++; if (rd_a_out !== 16'h1111) begin miscompares++; $display("[TB] FAIL b2b_first got %h want 1111", rd_a_out); end
      step(); idle(); alu_q_in = 16'h2222; #1;
      vectors++; if (rd_a_out !== 16'h2222) begin miscompares++; $display("[TB] FAIL b2b_second got %h want 2222", rd_a_out); end
      step(); alu_q_in = 16'h0000; #1;
      vectors++; if (rd_a_out !== 16'h2222) begin miscompares++; $display("[TB] FAIL b2b_stored got %h want 2222", rd_a_out); end
   endtask

   // Reset while a Y write is pending discards it and restores CC.
   task automatic test_reset_midop();
      rd_sel_a_in = 4'h2;
      issue(4'h2, 1'b1, 1'b1, 1'b1);
      step(); idle(); alu_q_in = 16'hBEEF; alu_ccr_in = 8'h0F; rst_in = 1'b1; #1;
      vectors++; if (pc_wr_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_pcwr got %b want 0", pc_wr_out); end
      step(); rst_in = 1'b0; alu_q_in = 16'h0000; alu_ccr_in = 8'h00; #1;
      vectors++; if (rd_a_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL midrst_y got %h want 0000", rd_a_out); end
      vectors++; if (ccr_out !== 8'h50) begin miscompares++; $display("[TB] FAIL midrst_cc got %h want 50", ccr_out); end
      vectors++; if (pc_wr_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_pcwr2 got %b want 0", pc_wr_out); end
   endtask

   // Run every scenario in order and report the totals.
   initial begin
      test_reset();
      test_forward16();
      test_byte_merge();
      test_width();
      test_cc();
      test_pc_write();
      test_back_to_back();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Register file and writeback stage for the 6809/6309 core.
- Supplies the ALU operand buses during issue and captures the ALU result (q_out) and flags (CCRo) one cycle later.
- Commits results to A, B, X, Y, U, S, DP and CC.
- Forwards an in-flight result to the read ports so back-to-back dependent operations need no stall.

Parameters:
- CC_RESET, 8'h50, CC value after reset (I and F masked).
- UNUSED_READ, 16'hFFFF, read value for unimplemented register codes.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- issue_valid_in  in  1  operation issued to ALU this cycle.
- issue_dst_in  in  4  destination register code.
- issue_wr_in  in  1  write result to destination.
- issue_wcc_in  in  1  write ALU flags to CC.
- issue_sz_in  in  1  result size, 0 = 8-bit, 1 = 16-bit.
- alu_q_in  in  16  ALU result.
- alu_ccr_in  in  8  ALU flags output.
- rd_sel_a_in  in  4  read port A register code.
- rd_sel_b_in  in  4  read port B register code.
- pc_in  in  16  current PC, returned for code 5.
- rd_a_out  out  16  read port A data.
- rd_b_out  out  16  read port B data.
- ccr_out  out  8  CC register to ALU; registered, never bypassed.
- pc_wr_out  out  1  PC write strobe.
- pc_wr_data_out  out  16  PC write data.

Behaviour:
- Reset is synchronous and active-high on rst_in; single clock clk_in.
- Register codes (TFR/EXG encoding):
  - 0 D (= A:B)
  - 1 X, 2 Y, 3 U, 4 S
  - 5 PC
  - 8 A, 9 B
  - A CC, B DP
  - 6, 7, C–F unused: reads return UNUSED_READ; writes are ignored.
- Reset state:
  - A, B, X, Y, U, S, DP = 0; CC = CC_RESET.
  - Pending stage cleared; pc_wr_out = 0.
- Reads:
  - Combinational.
  - 8-bit registers read as {8'hFF, reg}.
  - Code 5 returns pc_in.
- Pipeline timing:
  - Issue in cycle N latches issue_dst, wr, wcc and sz into the pending stage at the end of cycle N; the ALU registers its operands on the same edge.
  - In cycle N+1, alu_q_in and alu_ccr_in are valid.
  - At the end of cycle N+1, if pending valid: register write when wr=1; CC <= alu_ccr_in when wcc=1.
  - Committed value is visible from cycle N+2.
- Width rules:
  - 16-bit result to an 8-bit register: writes q[7:0].
  - 8-bit result to a 16-bit register: writes {8'hFF, q[7:0]}.
  - Result to D: A <= q[15:8] and B <= q[7:0] when sz=1; B <= q[7:0] and A <= FF when sz=0.
- Forwarding:
  - In cycle N+1, a read matching the pending destination with wr=1 returns the value about to be written.
  - Granularity is per byte: pending A or B with a read of D merges the forwarded byte with the stored byte; pending D with a read of A or B returns the matching byte.
  - No forwarding for CC. ccr_out always reflects the CC register, which avoids a combinational loop through the ALU flags. A dependent flag consumer issued in cycle N+1 sees the updated CC in cycle N+2, which is the cycle its ALU evaluation occurs.
- Write conflicts:
  - dst = CC with wr=1 and wcc=1: the register write (q[7:0]) wins.
  - dst = PC with wr=1: no register update. pc_wr_out = 1 combinationally during cycle N+1 and pc_wr_data_out = alu_q_in. pc_wr_data_out = 0 when pc_wr_out = 0.
- issue_valid_in = 0: the pending stage becomes invalid and no write occurs.
- Back-to-back issue every cycle is supported; each pending entry commits exactly once.
- Reset mid-operation: a pending entry is discarded, no write, CC = CC_RESET on the following cycle.

Test Plan:
- Reset: assert rst_in 2 cycles -> rd_a_out(sel=1) = 0000, ccr_out = 50, pc_wr_out = 0; rd_a_out(sel=8) = FF00; rd_a_out(sel=6) = FFFF.
- 16-bit write with forwarding: issue dst=1 wr=1 sz=1 at N; alu_q_in = 1234 at N+1 -> rd_a_out(sel=1) = 1234 in N+1 (forwarded) and N+2 (stored).
- Byte merge: with D = 0000, issue dst=8 sz=0, alu_q_in = 00AB -> rd_b_out(sel=0) = AB00 in N+1 and N+2; then dst=0 sz=1, q = 5A6B -> A reads FF5A, B reads FF6B.
- Compare-style write: issue wr=0 wcc=1, alu_ccr_in = 54 -> all registers unchanged; ccr_out = 54 from N+2; ccr_out unchanged in N+1.
- CC conflict: dst=A(code A) wr=1 wcc=1, q = 0003, alu_ccr_in = FF -> ccr_out = 03. PC write: dst=5, q = C000 -> pc_wr_out = 1 for exactly one cycle with data C000.
- Reset mid-operation: issue dst=2 at N, rst_in = 1 in N+1 -> Y remains 0000, no pc_wr_out, ccr_out = 50.
